// File: rtl/gen_slffr_bank_if.sv
// Request and status bundle for the set-lead flag bank.
// The master drives set/clear/flush requests; the slave (the bank) returns flag state.
interface gen_slffr_bank_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned SP = 2,
  parameter int unsigned CP = 2,
  parameter int unsigned AW = $clog2(DW),
  parameter int unsigned CW = $clog2(DW + 1)
);
  logic [SP-1:0]    set_vld;
  logic [SP*AW-1:0] set_idx;
  logic [CP-1:0]    clr_vld;
  logic [CP*AW-1:0] clr_idx;
  logic             flush;
  logic [DW-1:0]    qout;
  logic [DW-1:0]    qreg;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output set_vld, set_idx, clr_vld, clr_idx, flush,
    input  qout, qreg, cnt, full, empty, err
  );

  modport slave (
    input  set_vld, set_idx, clr_vld, clr_idx, flush,
    output qout, qreg, cnt, full, empty, err
  );
endinterface

// File: rtl/gen_slffr_bank.sv
// Multi-port set-lead flag bank: indexed set/clear ports, global flush,
// occupancy count and a sticky protocol-error flag.
module gen_slffr_bank #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   SP      = 2,
  parameter int unsigned   CP      = 2,
  parameter int unsigned   AW      = $clog2(DW),
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter bit            SET_WIN = 1'b1,
  parameter bit            BYPASS  = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  gen_slffr_bank_if.slave   bus
);
  localparam int unsigned CW = $clog2(DW + 1);

  function automatic logic [CW-1:0] popcnt(input logic [DW-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DW; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  localparam logic [CW-1:0] RST_CNT = popcnt(RST_VAL);

  logic [DW-1:0] q_r;
  logic [DW-1:0] q_nxt;
  logic [DW-1:0] set_hit;
  logic [DW-1:0] clr_hit;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt;
  logic          err_r;
  logic          err_nxt;
  logic          idx_oob;
  logic          dup_set;
  logic          dbl_set;
  logic          bad_clr;

  // Per-entry decode of all ports; out-of-range indices hit nothing but are flagged.
  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    idx_oob = 1'b0;
    dup_set = 1'b0;
    for (int unsigned p = 0; p < SP; p++) begin
      if (bus.set_vld[p]) begin
        if (32'(bus.set_idx[p*AW +: AW]) >= DW) idx_oob = 1'b1;
        for (int unsigned i = 0; i < DW; i++)
          if (bus.set_idx[p*AW +: AW] == AW'(i)) set_hit[i] = 1'b1;
        for (int unsigned r = p + 1; r < SP; r++)
          if (bus.set_vld[r] && (bus.set_idx[r*AW +: AW] == bus.set_idx[p*AW +: AW]))
            dup_set = 1'b1;
      end
    end
    for (int unsigned c = 0; c < CP; c++) begin
      if (bus.clr_vld[c]) begin
        if (32'(bus.clr_idx[c*AW +: AW]) >= DW) idx_oob = 1'b1;
        for (int unsigned i = 0; i < DW; i++)
          if (bus.clr_idx[c*AW +: AW] == AW'(i)) clr_hit[i] = 1'b1;
      end
    end
  end

  // Next state with flush dominating, then the set/clear conflict policy.
  always_comb begin
    q_nxt   = q_r;
    dbl_set = |(set_hit & q_r & ~clr_hit);
    bad_clr = |(clr_hit & ~q_r & ~set_hit);
    if (bus.flush)    q_nxt = '0;
    else if (SET_WIN) q_nxt = (q_r & ~clr_hit) | set_hit;
    else              q_nxt = (q_r | set_hit) & ~clr_hit;
    err_nxt = err_r | (~bus.flush & (idx_oob | dup_set | dbl_set | bad_clr));
    cnt_nxt = popcnt(q_nxt);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q_r   <= RST_VAL;
      cnt_r <= RST_CNT;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      cnt_r <= cnt_nxt;
      err_r <= err_nxt;
    end
  end

  // Only sets are forwarded; clears and flush land on qout a cycle later.
  assign bus.qout  = BYPASS ? (q_r | set_hit) : q_r;
  assign bus.qreg  = q_r;
  assign bus.cnt   = cnt_r;
  assign bus.err   = err_r;
  assign bus.full  = (cnt_r == CW'(DW));
  assign bus.empty = (cnt_r == '0);
endmodule

// File: tb/tb_gen_slffr_bank.sv
// Bench for gen_slffr_bank: a set-wins/bypass instance and a clear-wins/no-bypass
// instance share stimulus and are compared against a per-entry flag model.
module tb_gen_slffr_bank;
  localparam int unsigned DW = 8;
  localparam int unsigned SP = 2;
  localparam int unsigned CP = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned VW = 2 * (DW + CW + 3) + 2 * DW;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  gen_slffr_bank_if #(.DW(DW), .SP(SP), .CP(CP)) bus1 ();
  gen_slffr_bank_if #(.DW(DW), .SP(SP), .CP(CP)) bus0 ();

  assign bus0.set_vld = bus1.set_vld;
  assign bus0.set_idx = bus1.set_idx;
  assign bus0.clr_vld = bus1.clr_vld;
  assign bus0.clr_idx = bus1.clr_idx;
  assign bus0.flush   = bus1.flush;

  gen_slffr_bank #(.DW(DW), .SP(SP), .CP(CP), .SET_WIN(1'b1), .BYPASS(1'b1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .bus(bus1.slave));
  gen_slffr_bank #(.DW(DW), .SP(SP), .CP(CP), .SET_WIN(1'b0), .BYPASS(1'b0)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .bus(bus0.slave));

  int checks = 0;
  int errors = 0;

  // Model: flag vectors and sticky error for each policy.
  logic [DW-1:0] mq1, mq0;
  logic          me1, me0;

  function automatic logic [DW-1:0] hits(input bit is_set);
    logic [DW-1:0] h;
    int n;
    h = '0;
    n = is_set ? int'(SP) : int'(CP);
    for (int p = 0; p < n; p++) begin
      logic v;
      int   idx;
      v   = is_set ? bus1.set_vld[p] : bus1.clr_vld[p];
      idx = is_set ? int'(bus1.set_idx[p*AW +: AW]) : int'(bus1.clr_idx[p*AW +: AW]);
      if (v && idx < int'(DW)) h[idx] = 1'b1;
    end
    return h;
  endfunction

  task automatic upd(inout logic [DW-1:0] q, inout logic e, input bit setwin);
    logic [DW-1:0] s, c;
    s = hits(1'b1);
    c = hits(1'b0);
    if (!bus1.flush) begin
      for (int p = 0; p < int'(SP); p++) begin
        if (bus1.set_vld[p] && int'(bus1.set_idx[p*AW +: AW]) >= int'(DW)) e = 1'b1;
        for (int r = p + 1; r < int'(SP); r++)
          if (bus1.set_vld[p] && bus1.set_vld[r] &&
              bus1.set_idx[p*AW +: AW] == bus1.set_idx[r*AW +: AW]) e = 1'b1;
      end
      for (int k = 0; k < int'(CP); k++)
        if (bus1.clr_vld[k] && int'(bus1.clr_idx[k*AW +: AW]) >= int'(DW)) e = 1'b1;
      for (int i = 0; i < int'(DW); i++) begin
        if (s[i] && q[i] && !c[i]) e = 1'b1;
        if (c[i] && !q[i] && !s[i]) e = 1'b1;
      end
    end
    for (int i = 0; i < int'(DW); i++) begin
      if (bus1.flush)       q[i] = 1'b0;
      else if (s[i] && c[i]) q[i] = setwin;
      else if (s[i])        q[i] = 1'b1;
      else if (c[i])        q[i] = 1'b0;
    end
  endtask

  function automatic logic [VW-1:0] exp_all();
    int n1, n0;
    n1 = $countones(mq1);
    n0 = $countones(mq0);
    return {mq1, CW'(n1), n1 == int'(DW), n1 == 0, me1,
            mq0, CW'(n0), n0 == int'(DW), n0 == 0, me0,
            mq1 | hits(1'b1), mq0};
  endfunction

  function automatic logic [VW-1:0] obs_all();
    return {bus1.qreg, bus1.cnt, bus1.full, bus1.empty, bus1.err,
            bus0.qreg, bus0.cnt, bus0.full, bus0.empty, bus0.err,
            bus1.qout, bus0.qout};
  endfunction

  task automatic drive(input logic [SP-1:0] sv, input logic [SP*AW-1:0] si,
                       input logic [CP-1:0] cv, input logic [CP*AW-1:0] ci, input logic fl);
    bus1.set_vld = sv;
    bus1.set_idx = si;
    bus1.clr_vld = cv;
    bus1.clr_idx = ci;
    bus1.flush   = fl;
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, 1'b0);
  endtask

  // One clock: model advances at the edge, outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge CLK);
    upd(mq1, me1, 1'b1);
    upd(mq0, me0, 1'b0);
    @(negedge CLK);
  endtask

  task automatic model_reset();
    mq1 = '0; mq0 = '0; me1 = 1'b0; me0 = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle();
    model_reset();
    #1;
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.empty, bus1.full, bus1.err} !== {8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset qreg=%h cnt=%0d empty=%b full=%b err=%b, want 00/0/1/0/0",
               bus1.qreg, bus1.cnt, bus1.empty, bus1.full, bus1.err);
    end
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL reset_model got %h want %h", obs_all(), exp_all());
    end
  endtask

  task automatic test_set_bypass();
    drive(2'b01, {3'd0, 3'd3}, '0, '0, 1'b0);
    #1;
    checks++;
    if ({bus1.qout, bus1.qreg, bus0.qout} !== {8'h08, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL bypass qout1=%h qreg1=%h qout0=%h, want 08/00/00",
               bus1.qout, bus1.qreg, bus0.qout);
    end
    tick();
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.empty} !== {8'h08, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL set_latency qreg=%h cnt=%0d empty=%b, want 08/1/0", bus1.qreg, bus1.cnt, bus1.empty);
    end
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL set_model got %h want %h", obs_all(), exp_all());
    end
  endtask

  task automatic test_multi_port();
    drive(2'b11, {3'd6, 3'd5}, 2'b01, {3'd0, 3'd3}, 1'b0);
    tick();
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.err} !== {8'h60, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL multi_port qreg=%h cnt=%0d err=%b, want 60/2/0", bus1.qreg, bus1.cnt, bus1.err);
    end
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL multi_model got %h want %h", obs_all(), exp_all());
    end
  endtask

  task automatic test_conflict();
    drive(2'b01, {3'd0, 3'd5}, 2'b01, {3'd0, 3'd5}, 1'b0);
    tick();
    checks++;
    if ({bus1.qreg, bus1.err, bus0.qreg, bus0.err} !== {8'h60, 1'b0, 8'h40, 1'b0}) begin
      errors++;
      $display("FAIL conflict qreg1=%h err1=%b qreg0=%h err0=%b, want 60/0/40/0",
               bus1.qreg, bus1.err, bus0.qreg, bus0.err);
    end
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL conflict_model got %h want %h", obs_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_fill_flush();
    idle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, {AW'(2*k+1), AW'(2*k)}, '0, '0, 1'b0);
      tick();
    end
    checks++;
    if ({bus1.full, bus1.cnt, bus0.full, bus0.cnt} !== {1'b1, 4'd8, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL fill full1=%b cnt1=%0d full0=%b cnt0=%0d, want 1/8/1/8",
               bus1.full, bus1.cnt, bus0.full, bus0.cnt);
    end
    drive(2'b01, {3'd0, 3'd0}, '0, '0, 1'b1);
    tick();
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.empty, bus1.err, bus0.qreg, bus0.err} !==
        {8'h00, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL flush qreg=%h cnt=%0d empty=%b err=%b qreg0=%h err0=%b, want 00/0/1/0/00/0",
               bus1.qreg, bus1.cnt, bus1.empty, bus1.err, bus0.qreg, bus0.err);
    end
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL flush_model got %h want %h", obs_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_errors();
    for (int cs = 0; cs < 3; cs++) begin
      idle();
      do_reset();
      if (cs == 0) begin
        drive(2'b01, {3'd0, 3'd2}, '0, '0, 1'b0);
        tick();
      end
      checks++;
      if ({bus1.err, bus0.err} !== 2'b00) begin
        errors++;
        $display("FAIL err_pre case%0d err1=%b err0=%b, want 0/0", cs, bus1.err, bus0.err);
      end
      case (cs)
        0:       drive(2'b01, {3'd0, 3'd2}, '0, '0, 1'b0);
        1:       drive(2'b11, {3'd4, 3'd4}, '0, '0, 1'b0);
        default: drive('0, '0, 2'b01, {3'd0, 3'd7}, 1'b0);
      endcase
      tick();
      checks++;
      if ({bus1.err, bus0.err} !== 2'b11) begin
        errors++;
        $display("FAIL err_set case%0d err1=%b err0=%b, want 1/1", cs, bus1.err, bus0.err);
      end
      drive('0, '0, '0, '0, 1'b1);
      tick();
      checks++;
      if (obs_all() !== exp_all() || bus1.err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky case%0d got %h want %h", cs, obs_all(), exp_all());
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    drive(2'b01, {3'd0, 3'd5}, '0, '0, 1'b0);
    tick();
    drive(2'b11, {3'd2, 3'd1}, '0, '0, 1'b0);
    #2;
    RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.err, bus0.qreg, bus0.cnt, bus0.err} !==
        {8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset qreg=%h cnt=%0d err=%b qreg0=%h cnt0=%0d err0=%b, want zeros",
               bus1.qreg, bus1.cnt, bus1.err, bus0.qreg, bus0.cnt, bus0.err);
    end
    @(negedge CLK);
    checks++;
    if (obs_all() !== exp_all()) begin
      errors++;
      $display("FAIL async_hold got %h want %h", obs_all(), exp_all());
    end
    RSTn = 1'b1;
    tick();
    checks++;
    if ({bus1.qreg, bus1.cnt, bus1.err} !== {8'h06, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL async_release qreg=%h cnt=%0d err=%b, want 06/2/0", bus1.qreg, bus1.cnt, bus1.err);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if (n % 40 == 0) begin
        idle();
        do_reset();
      end
      drive(SP'($urandom_range(0, 3)), (SP*AW)'($urandom),
            CP'($urandom_range(0, 3)), (CP*AW)'($urandom),
            $urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (obs_all() !== exp_all()) begin
        errors++;
        $display("FAIL rand_comb n=%0d got %h want %h", n, obs_all(), exp_all());
      end
      tick();
      checks++;
      if (obs_all() !== exp_all()) begin
        errors++;
        $display("FAIL rand_seq n=%0d got %h want %h", n, obs_all(), exp_all());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_set_bypass();
    test_multi_port();
    test_conflict();
    test_fill_flush();
    test_errors();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gen_slffr_bank.md
Name: gen_slffr_bank

Overview:
- Multi-port set-lead flag bank: DW flag bits with SP indexed set ports, CP indexed clear ports and a global flush.
- Generalises the single-bit set-lead flip-flop (output = set | stored) to an indexed vector with a configurable set/clear conflict policy, an occupancy count and a sticky protocol-error flag that replaces a simulation-only assert.
- Intended as the register/ROB-entry busy scoreboard between the rename/issue and writeback stages.

Parameters:
- DW, 32, number of flag entries (>=2).
- SP, 2, number of set ports.
- CP, 2, number of clear ports.
- AW, $clog2(DW), index width.
- RST_VAL, {DW{1'b0}}, flag vector value after reset.
- SET_WIN, 1, same-cycle set+clear on one entry: 1 = set wins, 0 = clear wins.
- BYPASS, 1, 1 = qout includes this cycle's sets; 0 = qout is the registered state only.

Ports:
- CLK  input  1  clock, all state updates on posedge.
- RSTn  input  1  asynchronous active-low reset.
- set_vld  input  SP  per-port set request.
- set_idx  input  SP*AW  per-port entry index; port p occupies bits [p*AW +: AW].
- clr_vld  input  CP  per-port clear request.
- clr_idx  input  CP*AW  per-port entry index; port c occupies bits [c*AW +: AW].
- flush  input  1  clear all entries next cycle.
- qout  output  DW  flag vector as seen by consumers (bypassed per BYPASS).
- qreg  output  DW  registered flag vector.
- cnt  output  $clog2(DW+1)  number of 1s in qreg.
- full  output  1  cnt == DW.
- empty  output  1  cnt == 0.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset: RSTn low asynchronously forces the following, held while RSTn is low:
  - qreg = RST_VAL;
  - cnt = popcount(RST_VAL);
  - err = 0;
  - full and empty derived from cnt.
  - An in-flight set, clear or flush in the reset cycle is discarded.
- Per-entry decode:
  - set_hit[i] = OR over p of (set_vld[p] & set_idx[p]==i).
  - clr_hit[i] = OR over c of (clr_vld[c] & clr_idx[c]==i).
  - Indices >= DW hit nothing.
- Next state for entry i, in priority order:
  - flush: 0. Flush dominates same-cycle sets and clears.
  - set_hit & clr_hit: SET_WIN ? 1 : 0.
  - set_hit only: 1.
  - clr_hit only: 0.
  - otherwise: hold.
- Latency: a set or clear is visible on qreg, cnt, full and empty one cycle after the request.
- qout (combinational):
  - BYPASS=1: qout = qreg | set_hit, giving zero-latency set visibility.
  - Clears and flush are never bypassed; they take effect on qout the following cycle.
  - BYPASS=0: qout = qreg.
- cnt is a register loaded each cycle with popcount(next state), so it always equals popcount(qreg). No carry is needed at DW: the width holds DW exactly.
- Multiple set ports naming the same entry in one cycle yield a single set, and cnt increments once.
- err: sticky, cleared only by RSTn. Error checks are suppressed in a flush cycle. Otherwise err is set on the next edge if any of these occur:
  - a valid set index >= DW, or a valid clear index >= DW;
  - a set to an entry with qreg=1 and no same-cycle clear on it (double allocation);
  - two valid set ports carrying an equal index;
  - a clear to an entry with qreg=0 and no same-cycle set on it.
- Simultaneous set+clear on the same entry is legal: the policy is resolved by SET_WIN, with no err.
- No combinational path from qout to any input. The only combinational outputs are qout (through set_hit, BYPASS=1), full and empty; everything else is a flop output.

Test Plan (DW=8, SP=2, CP=2, SET_WIN=1, BYPASS=1, RST_VAL=0):
- Reset, then set port 0 idx 3 → qout=0x08 in the same cycle, qreg=0x00; next cycle qreg=0x08, cnt=1, empty=0.
- Same cycle: set p0 idx 5, set p1 idx 6, clr c0 idx 3 → next cycle qreg=0x60, cnt=2, err=0.
- qreg=0x60; set idx 5 and clr idx 5 together → qreg stays 0x60 with no err. Rebuild with SET_WIN=0 → qreg=0x40.
- Fill all 8 entries over four cycles → full=1, cnt=8. Then flush together with set idx 0 → next cycle qreg=0x00, cnt=0, empty=1, err=0.
- Error cases, each starting from err=0; each case → err=1 one cycle later and stays 1 across flush until RSTn:
  - set idx 2 while qreg[2]=1;
  - set p0 and p1 both idx 4;
  - clr idx 7 while qreg[7]=0.
- Assert RSTn low mid-cycle while set_vld=2'b11 → qreg, cnt and err go to 0 immediately, without waiting for a clock edge. After release, the first edge updates state normally.
